axi_rr_arbiter: RTL and testbench

Parametrised N-master arbiter for the AXI interconnect. It selects one requesting master per address/write channel and holds that grant until the slave-side handshake completes. Round-robin or fixed-priority mode is selected at run time, and a hold-timeout watchdog releases stalled grants. One instance sits in front of each shared AR/AW channel mux and drives its select lines.

---
 rtl/axi_rr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: N-master arbiter for a shared AXI AR/AW channel.
// Picks one requester (round-robin or fixed priority), locks the grant until
// the muxed channel handshakes, and releases stalled grants via a watchdog.
module axi_rr_arbiter #(
  parameter int NUM_M    = 4,
  parameter int IDX_W    = $clog2(NUM_M),
  parameter int MAX_HOLD = 256
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [NUM_M-1:0] valid_i,
  input  logic             handshake_i,
  input  logic             prio_mode_i,
  input  logic             err_clr_i,
  output logic [NUM_M-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o,
  output logic             locked_o,
  output logic             timeout_err_o
);

  // hold counter is at least one bit wide, even with the watchdog disabled
  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int DW   = IDX_W + 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_M    = IDX_W'(NUM_M - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  logic [IDX_W-1:0] fp_idx, rr_idx, win_idx, sel_idx;
  logic [DW-1:0]    rr_best;
  logic             rr_found, any_valid, grant_active, hold_expired;

  // Index increment with wrap at NUM_M-1 (NUM_M need not be a power of two).
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_M) ? '0 : idx + IDX_W'(1);
  endfunction

  // Distance from the round-robin pointer to master k, scanning upward with wrap.
  function automatic logic [DW-1:0] rr_dist(input logic [IDX_W-1:0] k,
                                            input logic [IDX_W-1:0] ptr);
    logic [DW-1:0] k_w, p_w;
    k_w = {1'b0, k};
    p_w = {1'b0, ptr};
    return (k_w >= p_w) ? (k_w - p_w) : (k_w + DW'(NUM_M) - p_w);
  endfunction

  assign any_valid    = |valid_i;
  assign win_idx      = prio_mode_i ? fp_idx : rr_idx;
  assign hold_expired = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LAST);

  // Arbitration: lowest set index (fixed) and nearest set index at/after rr_ptr (round-robin).
  always_comb begin
    fp_idx   = '0;
    rr_idx   = '0;
    rr_best  = '0;
    rr_found = 1'b0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (valid_i[k]) fp_idx = IDX_W'(k);
    end
    for (int k = 0; k < NUM_M; k++) begin
      if (valid_i[k] && (!rr_found || (rr_dist(IDX_W'(k), rr_ptr_q) < rr_best))) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(k);
        rr_best  = rr_dist(IDX_W'(k), rr_ptr_q);
      end
    end
  end

  // State register: all flops, asynchronously cleared.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      last_idx_q    <= '0;
      hold_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      last_idx_q    <= last_idx_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state: grant/lock/release decisions, pointer advance and watchdog.
  always_comb begin
    logic err_set;
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    last_idx_d    = last_idx_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_err_d = timeout_err_q;
    err_set       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          last_idx_d = win_idx;
          if (handshake_i) begin
            // single-cycle transfer: stay IDLE, move the pointer past the winner
            if (!prio_mode_i) rr_ptr_d = idx_inc(win_idx);
          end else begin
            state_d    = LOCKED;
            hold_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (handshake_i) begin
          // handshake wins over a watchdog expiry in the same cycle
          state_d    = IDLE;
          hold_cnt_d = '0;
          if (!prio_mode_i) rr_ptr_d = idx_inc(last_idx_q);
        end else if (hold_expired) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          err_set    = 1'b1;
          if (!prio_mode_i) rr_ptr_d = idx_inc(last_idx_q);
        end else if (MAX_HOLD > 0) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // a new timeout outranks a clear request arriving in the same cycle
    if (err_set)        timeout_err_d = 1'b1;
    else if (err_clr_i) timeout_err_d = 1'b0;
  end

  // Outputs: live arbitration in IDLE, frozen grant in LOCKED, nothing during reset.
  always_comb begin
    grant_active = 1'b0;
    sel_idx      = last_idx_q;
    locked_o     = 1'b0;
    if (state_q == LOCKED) begin
      grant_active = 1'b1;
      locked_o     = 1'b1;
    end else if (any_valid) begin
      grant_active = 1'b1;
      sel_idx      = win_idx;
    end
    if (!ARESETn) begin
      grant_active = 1'b0;
      sel_idx      = '0;
      locked_o     = 1'b0;
    end
  end

  // One-hot decode of the selected index.
  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_grant
    assign grant_o[gi] = grant_active && (sel_idx == IDX_W'(gi));
  end

  assign grant_idx_o   = sel_idx;
  assign grant_valid_o = grant_active;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: driver pushes model-predicted outputs into a scoreboard
// queue each cycle; a monitor pops and compares on the falling clock edge.
module tb_axi_rr_arbiter;
  localparam int NUM_M    = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [NUM_M-1:0] valid = '0;
  logic             hs = 1'b0, prio = 1'b0, clr = 1'b0;
  logic [NUM_M-1:0] grant;
  logic [IDX_W-1:0] gidx;
  logic             gvalid, locked, terr;

  typedef struct packed {
    logic [NUM_M-1:0] grant;
    logic [IDX_W-1:0] idx;
    logic             gv;
    logic             lk;
    logic             te;
  } exp_t;

  exp_t  exp_q[$];
  string lbl_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // behavioural reference state
  bit m_locked;
  int m_last, m_ptr, m_held;
  bit m_err;

  axi_rr_arbiter #(.NUM_M(NUM_M), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD)) dut (
    .ACLK(aclk), .ARESETn(aresetn), .valid_i(valid), .handshake_i(hs),
    .prio_mode_i(prio), .err_clr_i(clr), .grant_o(grant), .grant_idx_o(gidx),
    .grant_valid_o(gvalid), .locked_o(locked), .timeout_err_o(terr)
  );

  always #5 aclk = ~aclk;

  task automatic model_reset();
    m_locked = 0; m_last = 0; m_ptr = 0; m_held = 0; m_err = 0;
  endtask

  // Who would win right now: lowest index, or first requester at/after the pointer.
  function automatic int model_winner();
    if (prio) begin
      for (int m = 0; m < NUM_M; m++) if (valid[m]) return m;
      return -1;
    end
    for (int off = 0; off < NUM_M; off++) begin
      int m = (m_ptr + off) % NUM_M;
      if (valid[m]) return m;
    end
    return -1;
  endfunction

  // What happens at a rising edge given the inputs held during the past cycle.
  task automatic model_edge();
    int w;
    bit set_err;
    set_err = 0;
    if (!aresetn) begin
      model_reset();
      return;
    end
    if (!m_locked) begin
      w = model_winner();
      if (w >= 0) begin
        m_last = w;
        if (hs) begin
          if (!prio) m_ptr = (w + 1) % NUM_M;
        end else begin
          m_locked = 1; m_held = 0;
        end
      end
    end else if (hs) begin
      m_locked = 0;
      if (!prio) m_ptr = (m_last + 1) % NUM_M;
    end else begin
      m_held++;
      if (MAX_HOLD > 0 && m_held == MAX_HOLD) begin
        m_locked = 0;
        set_err  = 1;
        if (!prio) m_ptr = (m_last + 1) % NUM_M;
      end
    end
    if (set_err)  m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic push_expect(input string lbl);
    exp_t e;
    int w;
    e = '0;
    if (aresetn) begin
      if (m_locked) begin
        e.grant = NUM_M'(1) << m_last; e.idx = IDX_W'(m_last); e.gv = 1; e.lk = 1;
      end else begin
        w = model_winner();
        if (w >= 0) begin
          e.grant = NUM_M'(1) << w; e.idx = IDX_W'(w); e.gv = 1;
        end else begin
          e.idx = IDX_W'(m_last);
        end
      end
      e.te = m_err;
    end
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
  endtask

  task automatic cycle(input logic r, input logic [NUM_M-1:0] v, input logic h,
                       input logic p, input logic c, input string lbl);
    @(posedge aclk); #1;
    model_edge();
    aresetn = r; valid = v; hs = h; prio = p; clr = c;
    if (!aresetn) model_reset();
    push_expect(lbl);
  endtask

  // Random cycle; priority mode only flips while the reference is idle.
  task automatic rand_cycle();
    @(posedge aclk); #1;
    model_edge();
    aresetn = ($urandom_range(0, 99) >= 2);
    valid   = ($urandom_range(0, 3) == 0) ? '0 : NUM_M'($urandom_range(0, 15));
    hs      = ($urandom_range(0, 99) < 40);
    clr     = ($urandom_range(0, 99) < 10);
    if (!m_locked && $urandom_range(0, 99) < 10) prio = ~prio;
    if (!aresetn) model_reset();
    push_expect("random");
  endtask

  // Monitor: one comparison per cycle, on the falling edge.
  initial begin
    exp_t  e;
    exp_t  a;
    string l;
    forever begin
      @(negedge aclk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        a = {grant, gidx, gvalid, locked, terr};
        n_checks++;
        if (a === e) begin
          n_pass++;
          $display("[%0t] %-12s grant=%b idx=%0d gv=%b lk=%b terr=%b ok",
                   $time, l, grant, gidx, gvalid, locked, terr);
        end else begin
          $display("[%0t] FAIL %s: got grant=%b idx=%0d gv=%b lk=%b terr=%b, want grant=%b idx=%0d gv=%b lk=%b terr=%b",
                   $time, l, a.grant, a.idx, a.gv, a.lk, a.te, e.grant, e.idx, e.gv, e.lk, e.te);
        end
      end
    end
  end

  initial begin
    model_reset();
    // reset and idle
    cycle(0, 4'b0000, 0, 0, 0, "reset");
    cycle(0, 4'b0000, 0, 0, 0, "reset");
    cycle(1, 4'b0000, 0, 0, 0, "idle_empty");
    cycle(1, 4'b0000, 1, 0, 0, "hs_no_valid");
    // round-robin back-to-back: 0,1,2,3,0 then 1,2,3 to bring pointer to 0
    repeat (8) cycle(1, 4'b1111, 1, 0, 0, "rr_b2b");
    // locked grant ignores request changes
    cycle(1, 4'b0101, 0, 0, 0, "lock_grant");
    cycle(1, 4'b0100, 0, 0, 0, "lock_hold");
    cycle(1, 4'b0100, 0, 0, 0, "lock_hold");
    cycle(1, 4'b0100, 1, 0, 0, "lock_release");
    cycle(1, 4'b0100, 1, 0, 0, "next_grant");
    // fixed priority, then back to round-robin with preserved pointer
    repeat (3) cycle(1, 4'b1010, 1, 1, 0, "fixed_prio");
    cycle(1, 4'b1111, 1, 1, 0, "fixed_all");
    cycle(1, 4'b1111, 1, 0, 0, "rr_resume");
    cycle(1, 4'b1111, 1, 0, 0, "rr_resume");
    // watchdog on master 2
    cycle(1, 4'b0000, 0, 0, 0, "idle");
    cycle(1, 4'b0001, 1, 0, 0, "ptr_to_1");
    cycle(1, 4'b0100, 0, 0, 0, "wd_grant");
    repeat (4) cycle(1, 4'b0000, 0, 0, 0, "wd_locked");
    cycle(1, 4'b0000, 0, 0, 0, "wd_err");
    cycle(1, 4'b1111, 1, 0, 0, "wd_next");
    cycle(1, 4'b0000, 0, 0, 1, "err_clr");
    cycle(1, 4'b0000, 0, 0, 0, "err_gone");
    // handshake on the last allowed cycle wins over the watchdog
    cycle(1, 4'b0010, 0, 0, 0, "hs_edge_grant");
    repeat (3) cycle(1, 4'b0000, 0, 0, 0, "hs_edge_hold");
    cycle(1, 4'b0000, 1, 0, 0, "hs_edge_rel");
    cycle(1, 4'b0000, 0, 0, 0, "hs_edge_noerr");
    // timeout set beats a clear in the same cycle
    cycle(1, 4'b1000, 0, 0, 0, "set_vs_clr");
    repeat (3) cycle(1, 4'b0000, 0, 0, 0, "set_vs_clr");
    cycle(1, 4'b0000, 0, 0, 1, "set_vs_clr");
    cycle(1, 4'b0000, 0, 0, 0, "err_kept");
    cycle(1, 4'b0000, 0, 0, 1, "err_clr");
    // asynchronous reset while locked on master 3
    cycle(1, 4'b1000, 0, 0, 0, "rst_grant");
    cycle(1, 4'b1000, 0, 0, 0, "rst_locked");
    cycle(0, 4'b1000, 0, 0, 0, "rst_async");
    cycle(1, 4'b1000, 1, 0, 0, "rst_regrant");
    cycle(1, 4'b1111, 1, 0, 0, "rst_ptr");
    // randomized traffic
    repeat (300) rand_cycle();
    cycle(1, 4'b0000, 0, 0, 0, "drain");
    @(negedge aclk); #1;
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
